// File: rtl/door_access_ctrl.sv
// door_access_ctrl
//   Keypad sequencing controller for the password door lock. Collects
//   CODE_LEN-digit codes, unlocks on a match, counts wrong attempts into a
//   timed lockout, relocks after a timeout once the door is closed, and runs
//   the old-code / new-code / confirm password-change sequence.
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset
//   i_key_valid     one-cycle strobe, i_key_digit valid
//   i_key_digit     4-bit digit
//   i_key_clear     discard partial entry (strobe)
//   i_chg_req       request password change (strobe)
//   i_door_sensor   1 = door closed
//   o_door_locked   1 = lock engaged
//   o_correct_pulse one-cycle pulse on accepted code
//   o_wrong_pulse   one-cycle pulse on rejected code or failed confirm
//   o_chg_done      one-cycle pulse when a new code is committed
//   o_alarm         high throughout lockout
//   o_state_dbg     current state encoding
module door_access_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h1111,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    LOCKOUT_CYCLES = 1000,
  parameter int                    UNLOCK_CYCLES  = 500,
  parameter int                    ENTRY_TIMEOUT  = 200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_digit,
  input  logic       i_key_clear,
  input  logic       i_chg_req,
  input  logic       i_door_sensor,
  output logic       o_door_locked,
  output logic       o_correct_pulse,
  output logic       o_wrong_pulse,
  output logic       o_chg_done,
  output logic       o_alarm,
  output logic [2:0] o_state_dbg
);

  localparam int CW      = CODE_LEN * 4;
  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDLE_W  = $clog2(ENTRY_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_DIGIT   = CNT_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_ZERO    = {FAIL_W{1'b0}};
  localparam logic [FAIL_W-1:0] FAIL_ONE     = FAIL_W'(1);
  localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0]  TMR_ZERO     = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  TMR_ONE      = TMR_W'(1);
  localparam logic [TMR_W-1:0]  UNLOCK_LAST  = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ZERO    = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0] IDLE_ONE     = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(ENTRY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_LOCKED      = 3'd0,
    ST_CHECK       = 3'd1,
    ST_UNLOCKED    = 3'd2,
    ST_LOCKOUT     = 3'd3,
    ST_CHG_NEW     = 3'd4,
    ST_CHG_CONFIRM = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_entry, w_entry_nxt;
  logic [CW-1:0]     r_new_buf, w_new_buf_nxt;
  logic [CW-1:0]     r_code, w_code_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [FAIL_W-1:0] r_fail, w_fail_nxt, w_fail_inc;
  logic              r_chg_flag, w_chg_flag_nxt;
  logic              w_correct, w_wrong, w_done;
  logic              w_entry_state, w_key_acc, w_last_key, w_timeout, w_abort;
  logic [CW-1:0]     w_shifted;

  // Key qualification: digits are only taken in the entry states and a clear always wins
  always_comb begin
    w_entry_state = (r_state == ST_LOCKED) || (r_state == ST_CHG_NEW) ||
                    (r_state == ST_CHG_CONFIRM);
    w_key_acc     = w_entry_state && i_key_valid && !i_key_clear;
    w_last_key    = w_key_acc && (r_cnt == LAST_DIGIT);
    w_timeout     = w_entry_state && (r_cnt != CNT_ZERO) && !w_key_acc &&
                    (r_idle == IDLE_LAST);
    w_abort       = w_entry_state && (i_key_clear || w_timeout);
    w_shifted     = (r_entry << 4) | CW'(i_key_digit);
    w_fail_inc    = r_fail + FAIL_ONE;
  end

  // Idle timer: counts cycles since the last key only while a partial entry exists
  always_comb begin
    if (!w_entry_state || w_key_acc || w_abort) begin
      w_idle_nxt = IDLE_ZERO;
    end else if (r_cnt != CNT_ZERO) begin
      w_idle_nxt = r_idle + IDLE_ONE;
    end else begin
      w_idle_nxt = IDLE_ZERO;
    end
  end

  // Next-state, datapath and pulse decode
  always_comb begin
    w_state_nxt    = r_state;
    w_entry_nxt    = r_entry;
    w_new_buf_nxt  = r_new_buf;
    w_code_nxt     = r_code;
    w_cnt_nxt      = r_cnt;
    w_fail_nxt     = r_fail;
    w_chg_flag_nxt = r_chg_flag;
    w_tmr_nxt      = TMR_ZERO;
    w_correct      = 1'b0;
    w_wrong        = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        // a change request only counts at the start of an entry
        if (i_chg_req && (r_cnt == CNT_ZERO)) begin
          w_chg_flag_nxt = 1'b1;
        end else begin
          w_chg_flag_nxt = r_chg_flag;
        end
        if (w_abort) begin
          w_cnt_nxt = CNT_ZERO;
        end else if (w_last_key) begin
          w_entry_nxt = w_shifted;
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = ST_CHECK;
        end else if (w_key_acc) begin
          w_entry_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      ST_CHECK: begin
        if (r_entry == r_code) begin
          w_correct   = 1'b1;
          w_fail_nxt  = FAIL_ZERO;
          w_state_nxt = r_chg_flag ? ST_CHG_NEW : ST_UNLOCKED;
        end else begin
          w_wrong        = 1'b1;
          w_fail_nxt     = w_fail_inc;
          w_chg_flag_nxt = 1'b0;
          w_state_nxt    = (w_fail_inc == FAIL_MAX) ? ST_LOCKOUT : ST_LOCKED;
        end
      end
      ST_UNLOCKED: begin
        // timer saturates at expiry; the lock waits for the door to close
        if (r_tmr == UNLOCK_LAST) begin
          w_tmr_nxt   = r_tmr;
          w_state_nxt = i_door_sensor ? ST_LOCKED : ST_UNLOCKED;
        end else begin
          w_tmr_nxt = r_tmr + TMR_ONE;
        end
      end
      ST_LOCKOUT: begin
        if (r_tmr == LOCKOUT_LAST) begin
          w_fail_nxt  = FAIL_ZERO;
          w_state_nxt = ST_LOCKED;
        end else begin
          w_tmr_nxt = r_tmr + TMR_ONE;
        end
      end
      ST_CHG_NEW, ST_CHG_CONFIRM: begin
        if (w_abort) begin
          w_cnt_nxt      = CNT_ZERO;
          w_chg_flag_nxt = 1'b0;
          w_state_nxt    = ST_LOCKED;
        end else if (w_last_key) begin
          w_entry_nxt = w_shifted;
          w_cnt_nxt   = CNT_ZERO;
          if (r_state == ST_CHG_NEW) begin
            w_new_buf_nxt = w_shifted;
            w_state_nxt   = ST_CHG_CONFIRM;
          end else begin
            // confirm failure leaves both the stored code and fail count alone
            if (w_shifted == r_new_buf) begin
              w_code_nxt = r_new_buf;
              w_done     = 1'b1;
            end else begin
              w_wrong = 1'b1;
            end
            w_chg_flag_nxt = 1'b0;
            w_state_nxt    = ST_LOCKED;
          end
        end else if (w_key_acc) begin
          w_entry_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_cnt_nxt      = CNT_ZERO;
        w_chg_flag_nxt = 1'b0;
        w_state_nxt    = ST_LOCKED;
      end
    endcase
  end

  // State, datapath and registered output update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_LOCKED;
      r_entry         <= {CW{1'b0}};
      r_new_buf       <= {CW{1'b0}};
      r_code          <= DEFAULT_CODE;
      r_cnt           <= CNT_ZERO;
      r_idle          <= IDLE_ZERO;
      r_tmr           <= TMR_ZERO;
      r_fail          <= FAIL_ZERO;
      r_chg_flag      <= 1'b0;
      o_door_locked   <= 1'b1;
      o_correct_pulse <= 1'b0;
      o_wrong_pulse   <= 1'b0;
      o_chg_done      <= 1'b0;
      o_alarm         <= 1'b0;
      o_state_dbg     <= 3'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_entry         <= w_entry_nxt;
      r_new_buf       <= w_new_buf_nxt;
      r_code          <= w_code_nxt;
      r_cnt           <= w_cnt_nxt;
      r_idle          <= w_idle_nxt;
      r_tmr           <= w_tmr_nxt;
      r_fail          <= w_fail_nxt;
      r_chg_flag      <= w_chg_flag_nxt;
      o_door_locked   <= (w_state_nxt != ST_UNLOCKED);
      o_correct_pulse <= w_correct;
      o_wrong_pulse   <= w_wrong;
      o_chg_done      <= w_done;
      o_alarm         <= (w_state_nxt == ST_LOCKOUT);
      o_state_dbg     <= w_state_nxt;
    end
  end

endmodule

// File: doc/door_access_ctrl.md
Name: door_access_ctrl

Overview:
Keypad sequencing controller for the password door lock.
- Collects multi-digit codes from a keypad strobe interface and checks them against the stored code.
- Drives the lock, counts failed attempts and enforces a lockout period.
- Auto-relocks after a timeout.
- Runs a verified password-change sequence: old code, new code, confirm.
- Sits between the keypad scanner and the lock actuator / status LEDs.

Parameters:
CODE_LEN, 4, digits per code (4-bit digits, first-entered digit = most significant nibble)
DEFAULT_CODE, 16'h1111, stored code after reset (CODE_LEN*4 bits)
MAX_TRIES, 3, consecutive wrong codes that trigger lockout
LOCKOUT_CYCLES, 1000, lockout duration in clk cycles
UNLOCK_CYCLES, 500, unlocked time before relock is attempted
ENTRY_TIMEOUT, 200, idle cycles between keys before a partial entry is discarded

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
key_valid  in  1  one-cycle strobe, key_digit valid
key_digit  in  4  digit value, any of 0x0-0xF accepted
key_clear  in  1  discard partial entry (one-cycle strobe)
chg_req  in  1  request password change (one-cycle strobe)
door_sensor  in  1  1 = door closed, 0 = door open
door_locked  out  1  1 = lock engaged
correct_pulse  out  1  one-cycle pulse on accepted code
wrong_pulse  out  1  one-cycle pulse on rejected code or failed confirm
chg_done  out  1  one-cycle pulse when new code is committed
alarm  out  1  high throughout LOCKOUT
state_dbg  out  3  current state encoding

Behaviour:
- Single clock domain. rst is synchronous and active-high, with priority over all other inputs.
- Reset values: state=LOCKED, door_locked=1, correct_pulse=0, wrong_pulse=0, chg_done=0, alarm=0. Stored code=DEFAULT_CODE. Digit count, fail_cnt, chg_flag and all timers = 0.
- Reset mid-operation, including mid-change, restores DEFAULT_CODE and discards the partial entry.
- Entry buffer: CODE_LEN*4-bit shift-left register. Each accepted key shifts key_digit into the LSBs and increments the digit count.
- State encodings: LOCKED=0, CHECK=1, UNLOCKED=2, LOCKOUT=3, CHG_NEW=4, CHG_CONFIRM=5.
- LOCKED:
  - door_locked=1.
  - Keys accepted. When the count reaches CODE_LEN, go to CHECK next cycle and reset the count.
  - chg_req is honoured only when count==0. It sets chg_flag; otherwise it is ignored.
- CHECK (exactly one cycle):
  - Match, chg_flag=0: go to UNLOCKED, correct_pulse=1, fail_cnt=0.
  - Match, chg_flag=1: go to CHG_NEW, correct_pulse=1, fail_cnt=0.
  - Mismatch: wrong_pulse=1, fail_cnt+1, chg_flag cleared. If the new fail_cnt==MAX_TRIES, go to LOCKOUT; else go to LOCKED.
  - Latency: last digit on cycle N; pulses and door_locked=0 are visible on cycle N+2.
- UNLOCKED:
  - door_locked=0. Keys and chg_req ignored. Relock timer counts up to UNLOCK_CYCLES.
  - On expiry with door_sensor=1, go to LOCKED (door_locked=1 the following cycle).
  - If door_sensor=0 at expiry, hold UNLOCKED until door_sensor=1, then go to LOCKED. The lock never engages on an open door.
- LOCKOUT:
  - alarm=1, door_locked=1. Keys, key_clear and chg_req ignored.
  - After LOCKOUT_CYCLES cycles, go to LOCKED with fail_cnt=0 and alarm=0.
- CHG_NEW:
  - Collect CODE_LEN digits into new_buf, then go to CHG_CONFIRM. door_locked stays 1.
- CHG_CONFIRM:
  - Collect CODE_LEN digits.
  - Equal to new_buf: stored code <= new_buf, chg_done=1.
  - Not equal: wrong_pulse=1. fail_cnt is NOT incremented and the stored code is unchanged.
  - Either way, return to LOCKED with chg_flag=0.
- Entry timeout:
  - In LOCKED, CHG_NEW and CHG_CONFIRM with count>0, the idle timer counts cycles since the last key and restarts on every accepted key.
  - Reaching ENTRY_TIMEOUT discards the partial entry (count=0). In CHG states it also aborts to LOCKED with chg_flag=0.
  - No pulse is emitted on timeout.
- key_clear:
  - Same effect as a timeout in the same states.
  - key_clear and key_valid in the same cycle: the clear wins and the digit is dropped.
- Pulses are mutually exclusive and never asserted two cycles in a row.
- A code that matches the stored code during CHG_NEW is still accepted as the new code.

Test Plan:
- After reset: key 1,1,1,1 (one per 3 cycles) -> correct_pulse two cycles after the 4th key; door_locked=0. With door_sensor=1, door_locked=1 again UNLOCK_CYCLES later.
- Three wrong codes 2,3,4,5 -> wrong_pulse ×3, then alarm=1 and keys ignored for 1000 cycles. Afterwards, 1,1,1,1 unlocks.
- Key 1,1 then idle 200 cycles, then 1,1,1,1 -> partial entry discarded, single correct_pulse after the full code. Repeat with key_clear and key_valid together -> digit dropped.
- chg_req, 1111, 9876, 9876 -> chg_done. Then 1111 -> wrong_pulse; 9876 -> unlock.
- chg_req, 1111, 9876, 9875 -> wrong_pulse, fail_cnt unchanged, code still 1111. Then rst during CHG_NEW -> state_dbg=0, code 1111.
- Unlock, hold door_sensor=0 past UNLOCK_CYCLES -> door_locked stays 0. Raise door_sensor -> door_locked=1 one cycle later.
